// File: rtl/lbm_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lbm_step_sequencer
// Description : Time-step controller for the LBM core. Each time step runs a
//               collide phase then a stream phase through start/done
//               handshakes with the compute engines, then pulses the
//               time_step_counter Enable. A run ends after the step whose
//               Time_step reads MAX_TIME-1 at the advance point.
//
// Optional    : define LBM_STEP_WATCHDOG_EN to add a per-wait-phase watchdog
//               (TIMEOUT_CYCLES) with a sticky ERROR state. Without it, Error
//               is tied to 0 and no wait counter exists.
//
// Ports       : Clk           in   system clock, rising edge
//               Reset         in   asynchronous reset, active-high
//               Start         in   one-cycle pulse that begins a run
//               Time_step     in   current step from time_step_counter
//               Step_enable   out  one-cycle pulse to the counter Enable
//               Collide_start out  one-cycle launch pulse, collide engine
//               Collide_done  in   collide engine completion pulse
//               Stream_start  out  one-cycle launch pulse, stream engine
//               Stream_done   in   stream engine completion pulse
//               Phase         out  0=idle/done, 1=collide, 2=stream, 3=advance
//               Busy          out  high except in IDLE, DONE and ERROR
//               Sim_done      out  high (held) in DONE
//               Error         out  watchdog fault flag
//
// Revision    : 1.0 - initial release
// ============================================================================
module lbm_step_sequencer #(
    parameter int MAX_TIME         = 8,
    parameter int TIME_COUNT_WIDTH = $clog2(MAX_TIME)
`ifdef LBM_STEP_WATCHDOG_EN
    ,
    parameter int TIMEOUT_CYCLES   = 1024
`endif
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        Start,
    input  logic [TIME_COUNT_WIDTH-1:0] Time_step,
    output logic                        Step_enable,
    output logic                        Collide_start,
    input  logic                        Collide_done,
    output logic                        Stream_start,
    input  logic                        Stream_done,
    output logic [1:0]                  Phase,
    output logic                        Busy,
    output logic                        Sim_done,
    output logic                        Error
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [3:0] c_IDLE   = 4'd0;
    localparam logic [3:0] c_C_REQ  = 4'd1;
    localparam logic [3:0] c_C_WAIT = 4'd2;
    localparam logic [3:0] c_S_REQ  = 4'd3;
    localparam logic [3:0] c_S_WAIT = 4'd4;
    localparam logic [3:0] c_ADV    = 4'd5;
    localparam logic [3:0] c_SYNC   = 4'd6;
    localparam logic [3:0] c_DONE   = 4'd7;
`ifdef LBM_STEP_WATCHDOG_EN
    localparam logic [3:0] c_ERROR  = 4'd8;
`endif

    localparam logic [TIME_COUNT_WIDTH-1:0] c_LAST_STEP =
        TIME_COUNT_WIDTH'(MAX_TIME - 1);

    logic [3:0] r_state;
    logic [3:0] w_state_next;
    logic       r_last;
    logic [1:0] w_phase;
    logic       w_busy;

`ifdef LBM_STEP_WATCHDOG_EN
    // The counter holds k-1 during the k-th wait cycle, so the timeout fires
    // on the cycle whose increment would make it reach TIMEOUT_CYCLES-1.
    localparam int                c_WD_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYCLES - 2);

    logic [c_WD_W-1:0] r_wait_cnt;
    logic              w_timeout;

    assign w_timeout = (r_wait_cnt == c_WD_LAST);

    // Cleared whenever the FSM is outside a wait state, which makes it zero
    // on the first cycle of every C_WAIT / S_WAIT visit.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_wait_cnt <= '0;
        end else if ((r_state == c_C_WAIT) || (r_state == c_S_WAIT)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end else begin
            r_wait_cnt <= '0;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Next-state logic. Done inputs are only looked at in their own WAIT
    // state, and Start only in IDLE/DONE, so stray pulses fall through.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (Start) w_state_next = c_C_REQ;
            end
            c_C_REQ: begin
                w_state_next = c_C_WAIT;
            end
            c_C_WAIT: begin
                if (Collide_done) begin
                    w_state_next = c_S_REQ;
                end
`ifdef LBM_STEP_WATCHDOG_EN
                else if (w_timeout) begin
                    w_state_next = c_ERROR;
                end
`endif
            end
            c_S_REQ: begin
                w_state_next = c_S_WAIT;
            end
            c_S_WAIT: begin
                if (Stream_done) begin
                    w_state_next = c_ADV;
                end
`ifdef LBM_STEP_WATCHDOG_EN
                else if (w_timeout) begin
                    w_state_next = c_ERROR;
                end
`endif
            end
            c_ADV: begin
                w_state_next = c_SYNC;
            end
            // SYNC gives the counter one cycle to register its new value
            // before the next step could look at it.
            c_SYNC: begin
                w_state_next = r_last ? c_DONE : c_C_REQ;
            end
            c_DONE: begin
                if (Start) w_state_next = c_C_REQ;
            end
`ifdef LBM_STEP_WATCHDOG_EN
            c_ERROR: begin
                w_state_next = c_ERROR;
            end
`endif
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The end-of-run decision is taken from the counter value seen at ADV,
    // i.e. before the Step_enable pulse has advanced (and possibly wrapped) it.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_last <= 1'b0;
        end else if (r_state == c_ADV) begin
            r_last <= (Time_step == c_LAST_STEP);
        end
    end

    // ------------------------------------------------------------------------
    // Output decode - purely from the state register
    // ------------------------------------------------------------------------
    always_comb begin
        w_phase = 2'd0;
        w_busy  = 1'b0;
        case (r_state)
            c_C_REQ, c_C_WAIT: begin
                w_phase = 2'd1;
                w_busy  = 1'b1;
            end
            c_S_REQ, c_S_WAIT: begin
                w_phase = 2'd2;
                w_busy  = 1'b1;
            end
            c_ADV, c_SYNC: begin
                w_phase = 2'd3;
                w_busy  = 1'b1;
            end
            default: begin
                w_phase = 2'd0;
                w_busy  = 1'b0;
            end
        endcase
    end

    assign Phase         = w_phase;
    assign Busy          = w_busy;
    assign Collide_start = (r_state == c_C_REQ);
    assign Stream_start  = (r_state == c_S_REQ);
    assign Step_enable   = (r_state == c_ADV);
    assign Sim_done      = (r_state == c_DONE);

`ifdef LBM_STEP_WATCHDOG_EN
    assign Error = (r_state == c_ERROR);
`else
    assign Error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lbm_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lbm_step_sequencer
// Description : Self-checking bench for lbm_step_sequencer. Contains a model
//               of the external time_step_counter, an automatic done
//               responder for both engines, a step-countdown reference model
//               checked every cycle, and directed scenarios with literal
//               expectations. Define LBM_STEP_WATCHDOG_EN to also exercise
//               the watchdog with TIMEOUT_CYCLES=16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lbm_step_sequencer;

    localparam int MAX_TIME = 8;
    localparam int TW       = $clog2(MAX_TIME);
`ifdef LBM_STEP_WATCHDOG_EN
    localparam int TMO   = 16;
    localparam bit WD_EN = 1'b1;
`else
    localparam int TMO   = 1024;
    localparam bit WD_EN = 1'b0;
`endif

    logic          Clk          = 1'b0;
    logic          Reset        = 1'b1;
    logic          Start        = 1'b0;
    logic          Collide_done = 1'b0;
    logic          Stream_done  = 1'b0;
    logic [TW-1:0] Time_step    = '0;
    logic          Step_enable;
    logic          Collide_start;
    logic          Stream_start;
    logic [1:0]    Phase;
    logic          Busy;
    logic          Sim_done;
    logic          Error;

    always #5 Clk = ~Clk;

    lbm_step_sequencer #(
        .MAX_TIME         (MAX_TIME),
        .TIME_COUNT_WIDTH (TW)
`ifdef LBM_STEP_WATCHDOG_EN
        ,
        .TIMEOUT_CYCLES   (TMO)
`endif
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Start         (Start),
        .Time_step     (Time_step),
        .Step_enable   (Step_enable),
        .Collide_start (Collide_start),
        .Collide_done  (Collide_done),
        .Stream_start  (Stream_start),
        .Stream_done   (Stream_done),
        .Phase         (Phase),
        .Busy          (Busy),
        .Sim_done      (Sim_done),
        .Error         (Error)
    );

    // ---------------- external time_step_counter (not reset by Reset) -------
    logic          ts_load     = 1'b0;
    logic [TW-1:0] ts_load_val = '0;

    always @(posedge Clk) begin
        if (ts_load)
            Time_step <= ts_load_val;
        else if (Step_enable)
            Time_step <= (Time_step == TW'(MAX_TIME - 1)) ? '0 : Time_step + 1'b1;
    end

    // ---------------- reference model ---------------------------------------
    // A run is a countdown of steps_left = MAX_TIME - Time_step at Start.
    // Each step walks positions 0..5: 0 collide launch, 1 collide wait,
    // 2 stream launch, 3 stream wait, 4 advance, 5 settle.
    bit m_run  = 1'b0;
    bit m_done = 1'b0;
    bit m_err  = 1'b0;
    int m_pos  = 0;
    int m_left = 0;
    int m_wait = 0;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_run <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
            m_pos <= 0;    m_left <= 0;    m_wait <= 0;
        end else if (m_err) begin
            m_err <= 1'b1;
        end else if (!m_run) begin
            if (Start) begin
                m_run  <= 1'b1;
                m_done <= 1'b0;
                m_pos  <= 0;
                m_left <= MAX_TIME - int'(Time_step);
            end
        end else begin
            case (m_pos)
                0, 2: begin
                    m_pos  <= m_pos + 1;
                    m_wait <= 0;
                end
                1, 3: begin
                    if ((m_pos == 1 && Collide_done) || (m_pos == 3 && Stream_done))
                        m_pos <= m_pos + 1;
                    else if (WD_EN && (m_wait + 1 == TMO - 1)) begin
                        m_err <= 1'b1;
                        m_run <= 1'b0;
                    end else
                        m_wait <= m_wait + 1;
                end
                4: begin
                    m_left <= m_left - 1;
                    m_pos  <= 5;
                end
                default: begin
                    if (m_left == 0) begin
                        m_run  <= 1'b0;
                        m_done <= 1'b1;
                    end else
                        m_pos <= 0;
                end
            endcase
        end
    end

    function automatic logic [7:0] model_outputs();
        logic [1:0] ph;
        ph = !m_run ? 2'd0 : (m_pos < 2) ? 2'd1 : (m_pos < 4) ? 2'd2 : 2'd3;
        return {m_run && m_pos == 4, m_run && m_pos == 0, m_run && m_pos == 2,
                ph, m_run, m_done, m_err};
    endfunction

    function automatic logic [7:0] dut_outputs();
        return {Step_enable, Collide_start, Stream_start, Phase, Busy, Sim_done, Error};
    endfunction

    // ---------------- checking ----------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc_n    = 0;
    int se_cnt   = 0;
    int cs_cnt   = 0;
    int se_last  = 0;
    int gap_bad  = 0;
    bit auto_c   = 1'b0;
    bit auto_s   = 1'b0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge Clk);
    endtask

    task automatic compare_loop();
        @(posedge Clk);
        forever begin
            @(negedge Clk);
            cyc_n++;
            chk("model_outputs", dut_outputs(), model_outputs());
            if (Step_enable) begin
                if (se_cnt > 0 && (cyc_n - se_last) != 6) gap_bad++;
                se_cnt++;
                se_last = cyc_n;
            end
            if (Collide_start) cs_cnt++;
        end
    endtask

    // Returns each done pulse in the cycle after its start pulse.
    task automatic responder();
        logic cs_d;
        logic ss_d;
        cs_d = 1'b0;
        ss_d = 1'b0;
        forever begin
            @(posedge Clk);
            #1;
            if (auto_c) Collide_done = cs_d;
            if (auto_s) Stream_done  = ss_d;
            cs_d = Collide_start;
            ss_d = Stream_start;
        end
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        cyc();
        Start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (!Sim_done && n < MAX_TIME * 20) begin
            cyc();
            n++;
        end
        chk(nm, 8'(Sim_done), 8'd1);
    endtask

    task automatic run_tests();
        int n;
        // Reset held, then released
        repeat (3) cyc();
        Reset = 1'b0;
        cyc();
        chk("reset_outputs", dut_outputs(), 8'h00);

        // Full 8-step run with immediate done responses
        auto_c = 1'b1; auto_s = 1'b1;
        se_cnt = 0; cs_cnt = 0; gap_bad = 0;
        pulse_start();
        chk("collide_start_after_start", 8'(Collide_start), 8'd1);
        wait_done("run1_done");
        chk("run1_step_pulses", 8'(se_cnt), 8'd8);
        chk("run1_step_gap_errors", 8'(gap_bad), 8'd0);
        chk("run1_time_step_wrapped", 8'(Time_step), 8'd0);
        repeat (3) cyc();
        chk("sim_done_held", 8'(Sim_done), 8'd1);

        // Restart from DONE, with Start pulses while busy
        se_cnt = 0; cs_cnt = 0;
        pulse_start();
        chk("restart_clears_sim_done", 8'({Sim_done, Collide_start}), 8'b01);
        repeat (10) cyc(); pulse_start();
        repeat (7)  cyc(); pulse_start();
        repeat (13) cyc(); pulse_start();
        wait_done("run2_done");
        chk("run2_collide_starts", 8'(cs_cnt), 8'd8);
        chk("run2_step_pulses", 8'(se_cnt), 8'd8);

        // Manual handshakes: early collide done, stray stream done
        auto_c = 1'b0; auto_s = 1'b0; se_cnt = 0;
        pulse_start();
        Collide_done = 1'b1;                  // seen in C_REQ: ignored
        cyc();
        Collide_done = 1'b0; Stream_done = 1'b1;  // stray, in C_WAIT
        cyc();
        Stream_done = 1'b0;
        chk("stray_stream_done_ignored", 8'({Phase, Stream_start}), 8'b010);
        repeat (3) cyc();
        Collide_done = 1'b1;                  // 5th C_WAIT cycle: accepted
        cyc();
        Collide_done = 1'b0;
        chk("stream_start_after_collide_done", 8'({Stream_start, Phase}), 8'b110);
        auto_c = 1'b1; auto_s = 1'b1;
        wait_done("run3_done");
        chk("run3_step_pulses", 8'(se_cnt), 8'd8);

        // Asynchronous reset while in S_WAIT with Time_step = 2
        pulse_start();
        n = 0;
        while (Time_step != TW'(2) && n < 100) begin cyc(); n++; end
        chk("reached_step_2", 8'(Time_step), 8'd2);
        auto_s = 1'b0;
        n = 0;
        while (!(Phase == 2'd2 && !Stream_start) && n < 50) begin cyc(); n++; end
        chk("in_stream_wait", 8'({Phase, Busy}), 8'b101);
        repeat (3) cyc();
        #2 Reset = 1'b1;
        #1;
        chk("async_reset_outputs", dut_outputs(), 8'h00);
        cyc(); cyc();
        Reset = 1'b0; Stream_done = 1'b0; auto_s = 1'b1;
        cyc();
        se_cnt = 0;
        pulse_start();
        chk("post_reset_collide_start", 8'({Collide_start, Phase}), 8'b101);
        wait_done("run4_done");
        chk("run4_steps_from_2", 8'(se_cnt), 8'd6);

        // Mid-run entry at Time_step = 5; Start coincides with done pulses
        ts_load_val = TW'(5); ts_load = 1'b1;
        cyc();
        ts_load = 1'b0;
        chk("counter_preset", 8'(Time_step), 8'd5);
        auto_c = 1'b0; auto_s = 1'b0; se_cnt = 0;
        Start = 1'b1; Collide_done = 1'b1; Stream_done = 1'b1;
        cyc();
        Start = 1'b0; Collide_done = 1'b0; Stream_done = 1'b0;
        chk("start_beats_done_in_done", 8'({Collide_start, Sim_done, Busy}), 8'b101);
        auto_c = 1'b1; auto_s = 1'b1;
        wait_done("run5_done");
        chk("run5_steps_from_5", 8'(se_cnt), 8'd3);
        chk("run5_time_step_wrapped", 8'(Time_step), 8'd0);

`ifdef LBM_STEP_WATCHDOG_EN
        // Stream_done on the timeout cycle wins
        auto_s = 1'b0;
        pulse_start();
        n = 0;
        while (!Stream_start && n < 20) begin cyc(); n++; end
        chk("wd1_stream_req", 8'(Stream_start), 8'd1);
        repeat (TMO - 1) cyc();
        Stream_done = 1'b1;
        cyc();
        Stream_done = 1'b0;
        chk("wd_done_on_timeout_cycle", 8'({Step_enable, Error}), 8'b10);
        auto_s = 1'b1;
        wait_done("wd_run1_done");

        // Withheld Stream_done: sticky error
        auto_s = 1'b0;
        pulse_start();
        n = 0;
        while (!Stream_start && n < 20) begin cyc(); n++; end
        chk("wd2_stream_req", 8'(Stream_start), 8'd1);
        repeat (TMO - 1) cyc();
        chk("wd_no_early_error", 8'({Error, Busy}), 8'b01);
        cyc();
        chk("wd_error_raised", 8'({Error, Busy, Phase}), 8'b1000);
        pulse_start();
        cyc();
        chk("wd_error_sticky", 8'({Error, Collide_start, Busy}), 8'b100);
`endif
        repeat (2) cyc();
    endtask

    initial begin
        fork
            compare_loop();
            responder();
            run_tests();
        join_any
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lbm_step_sequencer.md
Name: lbm_step_sequencer

Overview:
Time-step controller for the LBM core. It drives the Enable input of time_step_counter and consumes its Data_out. Each time step runs a collide phase, then a stream phase, through start/done handshakes with the compute engines, then advances the counter. The run ends after MAX_TIME steps.

Parameters:
MAX_TIME, 8, number of time steps per run; the counter wraps from MAX_TIME-1 to 0
TIME_COUNT_WIDTH, $clog2(MAX_TIME), width of the counter value
TIMEOUT_CYCLES, 1024, watchdog limit in cycles per wait phase (used only with the optional feature)

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous reset, active-high
Start  in  1  one-cycle pulse that begins a run
Time_step  in  TIME_COUNT_WIDTH  current step, from time_step_counter Data_out
Step_enable  out  1  one-cycle pulse to the counter Enable; advances the step
Collide_start  out  1  one-cycle pulse that launches the collide engine
Collide_done  in  1  collide engine completion pulse
Stream_start  out  1  one-cycle pulse that launches the stream engine
Stream_done  in  1  stream engine completion pulse
Phase  out  2  0=idle/done, 1=collide, 2=stream, 3=advance
Busy  out  1  high in every state except IDLE, DONE and ERROR
Sim_done  out  1  high in DONE
Error  out  1  watchdog fault flag (optional feature)

Behaviour:
- Interface (already decided): one clock, Clk. Reset is asynchronous and active-high.
- Reset (asserted at any time, including mid-run): state goes to IDLE. All outputs are 0, the latched last flag is 0 and the watchdog count is 0.
- All outputs are registered or decoded directly from state. No combinational path from inputs to outputs.
- States and transitions:
  - IDLE: on Start, go to C_REQ.
  - C_REQ: Collide_start=1 for one cycle, then go to C_WAIT.
  - C_WAIT: on Collide_done, go to S_REQ.
  - S_REQ: Stream_start=1 for one cycle, then go to S_WAIT.
  - S_WAIT: on Stream_done, go to ADV.
  - ADV: Step_enable=1 for one cycle. Latch last=(Time_step==MAX_TIME-1). Go to SYNC.
  - SYNC: one cycle for the counter register to update. If last, go to DONE; else go to C_REQ.
  - DONE: Sim_done=1 and is held. On Start, go to C_REQ; Sim_done drops in that same cycle.
- Latency:
  - Start sampled in cycle n gives Collide_start in cycle n+1.
  - Minimum step length is 6 cycles, with each done pulse arriving the cycle after its start.
- Handshake rules:
  - Done inputs are sampled only in their own WAIT state.
  - A done pulse in a REQ state or any other state is ignored.
  - Collide_done seen in S_WAIT is ignored, and vice versa.
  - Start is ignored while Busy=1 or in ERROR.
- Wrap-around: the run ends on the step where Time_step reads MAX_TIME-1 at ADV. The counter wraps to 0 after that Step_enable.
- Mid-run entry: if Time_step is nonzero when Start arrives, the run ends at MAX_TIME-1. No steps are added for wrap.
- Simultaneous events: Start coinciding with a done pulse in DONE means Start wins. Done inputs have no effect in DONE.
- Phase decode: C_* states give 1, S_* states give 2, ADV/SYNC give 3, all others give 0.

Optional Feature:
- Macro: LBM_STEP_WATCHDOG_EN.
- Defined:
  - A wait counter clears on entry to C_WAIT and S_WAIT and increments each cycle in those states.
  - If it reaches TIMEOUT_CYCLES-1 with no done pulse, go to ERROR.
  - In ERROR: Error=1, Busy=0, Phase=0. This is sticky until Reset; Start is ignored.
  - A done pulse arriving in the same cycle as the timeout wins, and the normal transition is taken.
- Not defined: no wait counter, no ERROR state, Error tied to 0.

Test Plan:
- Reset at 1, then drop; check all outputs 0. Start pulse, Collide_done returned 1 cycle after each start -> Collide_start in the cycle after Start. 8 Step_enable pulses, 6 cycles apart. Sim_done rises after the 8th, with Time_step wrapped 7->0.
- Collide_done pulsed during C_REQ and again 5 cycles into C_WAIT -> only the second is accepted. Stream_start appears 1 cycle later. Stray Stream_done in C_WAIT has no effect.
- Start pulses while Busy -> ignored, with no extra Collide_start. Start in DONE -> Sim_done clears and a new 8-step run begins.
- Reset asserted in S_WAIT of step 3 -> all outputs 0 immediately (asynchronous). Next Start begins in C_REQ.
- Start with counter at Time_step=5 -> exactly 3 Step_enable pulses, then Sim_done.
- With LBM_STEP_WATCHDOG_EN and TIMEOUT_CYCLES=16, withhold Stream_done -> Error=1 after 15 wait cycles, Busy=0, Start ignored. Repeat with Stream_done on the timeout cycle -> no error, ADV taken.
